// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared Snake board FSM encoding and cell value constants
package snake_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } board_state_t;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_SNAKE = 2'd1;
  localparam logic [1:0] CELL_FOOD  = 2'd2;

endpackage

// File: rtl/board_clear_seq.sv
// rtl/board_clear_seq.sv - wipe address counter for the board SRAM
module board_clear_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  done
);

  assign done = (addr == ADDR_WIDTH'(DEPTH - 1));

  // Wrapping to 0 on the last cell leaves the counter ready for the next wipe.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      addr <= '0;
    end else if (en) begin
      addr <= done ? '0 : addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - board SRAM arbiter between video and game logic
// with a full-board wipe sequencer.
module board_ram_arbiter
  import snake_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 2,
  parameter int                    DEPTH       = 640,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(CELL_EMPTY),
  parameter int                    MAX_WAIT    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  output logic                  o_busy,
  input  logic                  i_vid_req,
  input  logic [ADDR_WIDTH-1:0] i_vid_addr,
  output logic                  o_vid_gnt,
  output logic                  o_vid_rvalid,
  output logic [DATA_WIDTH-1:0] o_vid_rdata,
  output logic                  o_vid_miss,
  input  logic                  i_game_req,
  input  logic                  i_game_we,
  input  logic [ADDR_WIDTH-1:0] i_game_addr,
  input  logic [DATA_WIDTH-1:0] i_game_wdata,
  output logic                  o_game_gnt,
  output logic                  o_game_rvalid,
  output logic [DATA_WIDTH-1:0] o_game_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_write,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  board_state_t          state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [ADDR_WIDTH-1:0] wipe_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  wipe_done;
  logic                  run;
  logic                  force_game;

  assign run        = (state == ST_RUN);
  assign force_game = (wait_cnt >= WAIT_W'(MAX_WAIT));

  // Video wins unless the game has been starved long enough to take one slot.
  assign o_vid_gnt  = run && i_vid_req && !force_game;
  assign o_game_gnt = run && i_game_req && (!i_vid_req || force_game);
  assign o_busy     = !run;

  always_comb begin
    o_ram_addr  = last_addr;
    o_ram_write = 1'b0;
    o_ram_wdata = i_game_wdata;
    if (!run) begin
      o_ram_addr  = wipe_addr;
      o_ram_write = 1'b1;
      o_ram_wdata = CLEAR_VALUE;
    end else if (o_vid_gnt) begin
      o_ram_addr = i_vid_addr;
    end else if (o_game_gnt) begin
      o_ram_addr  = i_game_addr;
      o_ram_write = i_game_we;
    end
  end

  assign o_vid_rdata  = i_ram_rdata;
  assign o_game_rdata = i_ram_rdata;

  board_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_clear_seq (
    .clk  (i_clk),
    .rst  (i_rst),
    .start(run && i_clear),
    .en   (!run),
    .addr (wipe_addr),
    .done (wipe_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_CLEAR;
      wait_cnt      <= '0;
      last_addr     <= '0;
      o_vid_miss    <= 1'b0;
      o_vid_rvalid  <= 1'b0;
      o_game_rvalid <= 1'b0;
    end else begin
      last_addr     <= o_ram_addr;
      o_vid_miss    <= i_vid_req && !o_vid_gnt;
      o_vid_rvalid  <= o_vid_gnt;
      o_game_rvalid <= o_game_gnt && !i_game_we;
      case (state)
        ST_CLEAR: begin
          wait_cnt <= '0;
          if (wipe_done) state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_clear) state <= ST_CLEAR;
          if (i_game_req && !o_game_gnt) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: doc/board_ram_arbiter.md
# board_ram_arbiter

Controller and arbiter for the single-port board SRAM (1-cycle registered read, no read on write cycles) holding the Snake playfield. It shares the RAM between the VGA renderer (read-only, latency-critical) and the game logic (read/write). It also sequences a full-board wipe on reset or on request. It sits between those two requesters and the `sram` instance and drives all SRAM ports.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: SRAM address width.
- `DATA_WIDTH`, default 2: cell width.
- `DEPTH`, default 640: number of cells wiped.
- `CLEAR_VALUE`, default 0: cell value written during a wipe.
- `MAX_WAIT`, default 4: number of cycles a pending game request may be refused before it is forced through.

Ports:
- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `i_clear`  in  1: request a board wipe.
- `o_busy`  out  1: high while a wipe is in progress.
- `i_vid_req`  in  1: video read request.
- `i_vid_addr`  in  ADDR_WIDTH: video read address.
- `o_vid_gnt`  out  1: video request accepted this cycle.
- `o_vid_rvalid`  out  1: video read data valid.
- `o_vid_rdata`  out  DATA_WIDTH: video read data.
- `o_vid_miss`  out  1: pulses when a video request is refused.
- `i_game_req`  in  1: game request.
- `i_game_we`  in  1: game request is a write.
- `i_game_addr`  in  ADDR_WIDTH: game address.
- `i_game_wdata`  in  DATA_WIDTH: game write data.
- `o_game_gnt`  out  1: game request accepted this cycle.
- `o_game_rvalid`  out  1: game read data valid.
- `o_game_rdata`  out  DATA_WIDTH: game read data.
- `o_ram_addr`  out  ADDR_WIDTH: SRAM address.
- `o_ram_write`  out  1: SRAM write enable.
- `o_ram_wdata`  out  DATA_WIDTH: SRAM write data.
- `i_ram_rdata`  in  DATA_WIDTH: SRAM read data.

## Operation
- FSM states are `CLEAR` and `RUN`. Reset enters `CLEAR` with the wipe address at 0.
- `CLEAR` state:
  - Each cycle: `o_ram_write`=1, `o_ram_addr`=wipe address, `o_ram_wdata`=CLEAR_VALUE; wipe address increments.
  - After writing address DEPTH-1, the FSM goes to `RUN`.
  - Both grants are 0.
  - `o_busy`=1.
  - `i_clear` is ignored.
- `RUN` state:
  - `o_busy`=0.
  - `i_clear`=1 moves the FSM to `CLEAR` on the next cycle with the wipe address reset to 0. Arbitration in the cycle where `i_clear` is sampled proceeds normally.
- Handshake:
  - req/gnt; a transfer occurs in any cycle with req && gnt.
  - A requester holds req, addr, we and wdata stable until granted.
  - gnt is combinational from req and state. Both grants are never high together.
- Arbitration in `RUN`:
  - Video has priority.
  - Game is granted when video does not request, or when `force`=1.
  - `force` is high when `wait_cnt >= MAX_WAIT`.
- `wait_cnt`:
  - Width $clog2(MAX_WAIT+1).
  - Increments (saturating) each cycle with i_game_req && !o_game_gnt.
  - Clears on a game grant, on !i_game_req, and in `CLEAR`.
- `o_vid_miss`: registered 1-cycle pulse. It fires for any cycle with i_vid_req && !o_vid_gnt, in either state.
- RAM mux:
  - The granted requester drives `o_ram_addr`.
  - `o_ram_write` = game grant && i_game_we; `o_ram_wdata` = i_game_wdata.
  - With no grant: `o_ram_write`=0 and addr holds the last value.
- Read return:
  - `o_vid_rvalid` is the video grant registered.
  - `o_game_rvalid` is (game grant && !i_game_we) registered.
  - Both `rdata` outputs pass `i_ram_rdata` through; the data is meaningful only when the matching rvalid is high.
  - Game writes produce no rvalid.

## Timing
- Read latency: grant in cycle N gives rvalid and data in cycle N+1. Throughput is one access per cycle.
- A write is committed at the clock edge ending its grant cycle. A read of the same address granted in N+1 returns the new data in N+2.
- A wipe takes exactly DEPTH cycles. `o_busy` falls in the first `RUN` cycle.
- Values after reset:
  - `o_busy`=1.
  - Grants, rvalids and `o_vid_miss` = 0.
  - `o_ram_write`=1 (wipe of address 0 starts).
- Reset during a wipe restarts the wipe at address 0. Reset during `RUN` drops any in-flight rvalid.
- Simultaneous `i_clear` and requests: the requests are served in that cycle; refusals begin the next cycle.
- Forced game slot: video is refused for exactly one cycle and `o_vid_miss` pulses. `wait_cnt` restarts from 0.

## Structure
- Shared package `snake_pkg` holds:
  - the FSM state encoding (`ST_CLEAR`, `ST_RUN`);
  - cell value constants (`CELL_EMPTY`=0, which is the CLEAR_VALUE default).
- A single sub-module, `board_clear_seq`, is natural: the wipe address counter with start/done.
- Arbitration and the mux live in the top module.

## Test plan
- Reset with DEPTH=640: 640 consecutive writes of 0 at addresses 0..639, then `o_busy`=0 at cycle 640. No grants during the wipe.
- Video reads 5, 6, 7 back-to-back in `RUN`: gnt each cycle. rvalid in cycles N+1..N+3 with data equal to RAM contents.
- Game write of 2 to address 100, then game read of 100: read returns 2 one cycle after its grant; `o_game_rvalid` is not asserted for the write.
- MAX_WAIT=4, video requests every cycle, game reads 10 continuously: game is granted in the 5th cycle of pending. Exactly one video refusal and one `o_vid_miss` pulse; the pattern repeats every 5 cycles.
- `i_clear` pulse mid-stream: requests served in the pulse cycle, `o_busy`=1 the next cycle, 640 writes follow, and all cells read back 0 afterwards.
- `i_rst` asserted at wipe address 300: the wipe restarts at 0 and completes 640 cycles after `i_rst` deasserts.
